// File: rtl/multi_channel_line_sum_accumulator.sv
// Per-channel frame accumulator: sums NUM_OF_LINES accepted line sums per channel
// and holds the frame totals under a valid/ready handshake until consumed.
module multi_channel_line_sum_accumulator #(
    parameter int  NUM_CH       = 2,
    parameter int  IN_W         = 18,
    parameter int  NUM_OF_LINES = 480,
    localparam int OUT_W        = IN_W + $clog2(NUM_OF_LINES),
    localparam int CNT_W        = $clog2(NUM_OF_LINES + 1)
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    sof,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*IN_W-1:0]  line_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*OUT_W-1:0] frame_sum,
    output logic [CNT_W-1:0]        lines_done,
    output logic                    frame_abort
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(NUM_OF_LINES);

    logic [1:0]                   state;
    logic [NUM_CH-1:0][OUT_W-1:0] acc;
    logic [NUM_CH-1:0][OUT_W-1:0] acc_next;
    logic [NUM_CH-1:0][OUT_W-1:0] frame_q;
    logic                         accept;
    logic                         cont;
    logic [CNT_W-1:0]             cnt_next;

    assign in_ready  = (state != HOLD);
    assign accept    = in_valid && in_ready;
    assign frame_sum = frame_q;

    // A line taken in IDLE, or together with sof, starts a new frame: load instead of add.
    assign cont     = (state == ACCUM) && !sof;
    assign cnt_next = cont ? lines_done + CNT_W'(1) : CNT_W'(1);

    always_comb begin
        acc_next = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            acc_next[k] = (cont ? acc[k] : '0) + OUT_W'(line_sum[k*IN_W +: IN_W]);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            frame_q     <= '0;
            lines_done  <= '0;
            out_valid   <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= sof && (state != IDLE);
            if (accept) begin
                acc        <= acc_next;
                lines_done <= cnt_next;
                if (cnt_next == LAST_LINE) begin
                    state     <= HOLD;
                    frame_q   <= acc_next;
                    out_valid <= 1'b1;
                end else begin
                    state     <= ACCUM;
                    out_valid <= 1'b0;
                end
            end else if (sof || (state == HOLD && out_ready)) begin
                // frame_q is left alone so the last total stays visible after delivery.
                state      <= IDLE;
                acc        <= '0;
                lines_done <= '0;
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/multi_channel_line_sum_accumulator.md
Name: multi_channel_line_sum_accumulator

Overview:
Parametrised successor of the single-channel line-sum accumulator. Accumulates per-line sums for NUM_CH independent channels over exactly NUM_OF_LINES accepted lines and presents one frame total per channel. Sits between the per-line sum stage and the frame-statistics consumer. Adds a valid/ready handshake, frame boundaries, a line counter, start-of-frame restart, abort reporting and result hold under backpressure.

Parameters:
NUM_CH, 2, number of independent channels.
IN_W, 18, width of one channel's line sum; equal to clog2(LINE_SIZE)+2*PIXEL_SIZE.
NUM_OF_LINES, 480, number of lines per frame; must be at least 1.
OUT_W, IN_W+clog2(NUM_OF_LINES) (derived, localparam), width of one channel's frame sum; overflow is impossible.
CNT_W, clog2(NUM_OF_LINES+1) (derived, localparam), line counter width.

Ports:
CLK  in  1  clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high reset.
sof  in  1  synchronous start-of-frame/restart strobe.
in_valid  in  1  line_sum is valid.
in_ready  out  1  block can accept a line.
line_sum  in  NUM_CH*IN_W  packed per-channel line sums; channel k is bits [k*IN_W +: IN_W], unsigned.
out_valid  out  1  frame_sum holds a complete frame.
out_ready  in  1  consumer accepts frame_sum.
frame_sum  out  NUM_CH*OUT_W  packed per-channel frame totals; channel k is bits [k*OUT_W +: OUT_W].
lines_done  out  CNT_W  lines accepted in the current frame.
frame_abort  out  1  one-cycle pulse when sof discards a partial or undelivered frame.

Behaviour:
- Reset (async assert, sync deassert by the system): state IDLE; all accumulators 0; frame_sum 0; lines_done 0; out_valid 0; frame_abort 0. in_ready is 1 after reset.
- States: IDLE (no lines accepted), ACCUM (1..NUM_OF_LINES-1 lines accepted), HOLD (frame complete, awaiting out_ready).
- in_ready = (state != HOLD), combinational from state. A line is accepted when in_valid && in_ready.
- IDLE, accept: each channel accumulator loads its line_sum (load, not add). lines_done becomes 1. Go to ACCUM, or to HOLD if NUM_OF_LINES == 1.
- ACCUM, accept: each accumulator adds its zero-extended line_sum. lines_done increments. On the accept that makes lines_done == NUM_OF_LINES, go to HOLD.
- No accept in IDLE or ACCUM: all state is held. Gaps on in_valid are allowed.
- Entering HOLD: frame_sum is registered with the final totals and out_valid rises. Latency is 1 cycle from the last accepted line to out_valid = 1.
- HOLD: frame_sum and out_valid are stable, and in_ready is 0. While out_ready is 0, the block holds indefinitely. When out_ready = 1, the handshake completes; the next cycle has state IDLE, out_valid 0, lines_done 0, accumulators 0. frame_sum keeps its last value while out_valid is 0.
- out_valid never falls without out_ready, except on sof or reset.
- sof (highest priority after reset), one cycle:
  - In ACCUM, or in HOLD before the handshake completes: frame_abort pulses 1 on the next cycle. The partial or pending frame is dropped, out_valid goes to 0, and the accumulators and lines_done clear.
  - In IDLE: no abort pulse; state stays cleared.
  - sof together with an accept (possible in IDLE/ACCUM only): the line is taken as line 1 of the new frame. Accumulators load line_sum, lines_done = 1, state ACCUM (or HOLD if NUM_OF_LINES == 1).
  - sof in HOLD with out_ready = 1 in the same cycle: sof wins. frame_abort pulses and the frame counts as not delivered.
- Arithmetic: unsigned, with each channel independent. The sum of NUM_OF_LINES values, each at most 2^IN_W-1, fits in OUT_W bits, so no saturation or wrap is required.
- Reset mid-frame clears immediately (async). No abort pulse is issued for reset.

Test Plan:
- NUM_CH=2, IN_W=8, NUM_OF_LINES=4, back-to-back lines ch0={10,20,30,40}, ch1={255,255,255,255}, out_ready=1 -> out_valid is 1 the cycle after the 4th accept; ch0=100, ch1=1020 (OUT_W=10, no overflow); lines_done 1,2,3,4 then 0.
- Same frame with in_valid gaps of 0-3 random cycles between lines -> identical totals; lines_done holds during gaps.
- out_ready=0 for 5 cycles after completion, with in_valid=1 throughout -> in_ready=0, frame_sum stable, no line lost; the next frame starts after the handshake and its totals are correct.
- sof after 2 lines (ch0 10,20), then 4 lines of 1 -> frame_abort single pulse; next result ch0=4. Also sof coincident with a line of 7 followed by 3 lines of 1 -> ch0=10.
- Reset asserted in ACCUM and in HOLD -> all outputs 0 immediately; no frame_abort; in_ready=1 after release.
- NUM_OF_LINES=1: line ch0=5 -> out_valid next cycle with ch0=5; sof in HOLD with out_ready=1 -> frame_abort pulses and out_valid drops.
